// File: rtl/systolic_result_drain_if.sv
// Result-drain bus: per-row result streams in, packed matrix_C out with valid/ready.
interface systolic_result_drain_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  logic [N*W-1:0]   row_data;
  logic [N-1:0]     row_valid;
  logic             c_ready;
  logic [N*N*W-1:0] matrix_C;
  logic             c_valid;

  modport master (output row_data, row_valid, c_ready, input matrix_C, c_valid);
  modport slave  (input row_data, row_valid, c_ready, output matrix_C, c_valid);
endinterface

// File: rtl/systolic_result_drain.sv
// Deskews the east-edge row streams of the NxN systolic array into one matrix_C word.
// Optional arrival-skew checking is enabled with SYSTOLIC_DRAIN_SKEW_CHECK_EN.
module systolic_result_drain #(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  systolic_result_drain_if.slave   bus,
  input  logic                     err_clear,
  output logic                     busy,
  output logic                     overflow,
  output logic                     timeout_err,
  output logic                     skew_err
);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam int unsigned MW = N * N * W;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_e;

  state_e               state_q, state_d;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0]        stage_q, stage_d;
  logic [MW-1:0]        matrix_q, matrix_d;
  logic [IW-1:0]        idle_q, idle_d;
  logic                 c_valid_q, c_valid_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;
  logic                 timeout_q, timeout_d;
  logic [N-1:0]         acc;
  logic                 all_full;

  // Next-state, staging writes and error detection
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stage_d    = stage_q;
    matrix_d   = matrix_q;
    idle_d     = idle_q;
    c_valid_d  = c_valid_q;
    overflow_d = overflow_q & ~err_clear;
    timeout_d  = timeout_q & ~err_clear;
    acc        = '0;
    all_full   = 1'b1;
    case (state_q)
      IDLE, COLLECT: begin
        for (int i = 0; i < N; i++) begin
          if (bus.row_valid[i]) begin
            if (cnt_q[i] < CW'(N)) acc[i] = 1'b1;
            else                   overflow_d = 1'b1;
          end
        end
        for (int i = 0; i < N; i++) begin
          if (acc[i]) begin
            stage_d[(i*N + int'(cnt_q[i]))*W +: W] = bus.row_data[i*W +: W];
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
          if (cnt_d[i] != CW'(N)) all_full = 1'b0;
        end
        if (all_full) begin
          matrix_d  = stage_d;
          c_valid_d = 1'b1;
          cnt_d     = '0;
          idle_d    = '0;
          state_d   = HOLD;
        end else if (|acc) begin
          idle_d  = '0;
          state_d = COLLECT;
        end else if (state_q == COLLECT && bus.row_valid == '0) begin
          // Abort a stalled frame; the last delivered matrix_C is kept
          if (idle_q == IW'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            stage_d   = '0;
            idle_d    = '0;
            state_d   = IDLE;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end
      end
      HOLD: begin
        if (|bus.row_valid) overflow_d = 1'b1;
        if (bus.c_ready) begin
          c_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == COLLECT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      stage_q    <= '0;
      matrix_q   <= '0;
      idle_q     <= '0;
      c_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stage_q    <= stage_d;
      matrix_q   <= matrix_d;
      idle_q     <= idle_d;
      c_valid_q  <= c_valid_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef SYSTOLIC_DRAIN_SKEW_CHECK_EN
  logic [CW-1:0] since_q, since_d;
  logic [N-1:0]  prev_q, prev_d;
  logic          skew_q, skew_d;
  logic          row0_start;

  // since_q counts cycles from row 0's first element (saturating); prev_q marks last-cycle accepts
  always_comb begin
    skew_d     = skew_q & ~err_clear;
    since_d    = since_q;
    prev_d     = acc;
    row0_start = acc[0] && (cnt_q[0] == '0);
    if (row0_start)                               since_d = CW'(1);
    else if (cnt_q[0] != '0 && since_q < CW'(N))  since_d = since_q + CW'(1);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (cnt_q[i] == '0) begin
          if (i == 0) begin
            for (int j = 1; j < N; j++)
              if (cnt_q[j] != '0) skew_d = 1'b1;
          end else if (cnt_q[0] == '0 && !row0_start) begin
            skew_d = 1'b1;
          end else if ((row0_start ? CW'(0) : since_q) != CW'(i)) begin
            skew_d = 1'b1;
          end
        end else if (!prev_q[i]) begin
          skew_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      since_q <= '0;
      prev_q  <= '0;
      skew_q  <= 1'b0;
    end else begin
      since_q <= since_d;
      prev_q  <= prev_d;
      skew_q  <= skew_d;
    end
  end

  assign skew_err = skew_q;
`else
  assign skew_err = 1'b0;
`endif

  assign bus.matrix_C = matrix_q;
  assign bus.c_valid  = c_valid_q;
  assign busy         = busy_q;
  assign overflow     = overflow_q;
  assign timeout_err  = timeout_q;
endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: skewed frames, backpressure, overflow, timeout, reset.
module tb_systolic_result_drain;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clear = 1'b0;
  logic busy, overflow, timeout_err, skew_err;
  int   tests_run = 0;
  int   failures = 0;

  systolic_result_drain_if #(.N(N), .W(W)) bus ();

  systolic_result_drain #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clock       (clk),
    .reset       (rst_n),
    .bus         (bus),
    .err_clear   (err_clear),
    .busy        (busy),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .skew_err    (skew_err)
  );

  always #5 clk = ~clk;

  function automatic logic [N*N*W-1:0] exp_matrix(input logic [7:0] base);
    logic [N*N*W-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[(i*N+j)*W +: W] = base + 8'(16*i + j);
    return m;
  endfunction

  // Inputs for frame cycle c: row i streams on cycles start..start+len-1
  task automatic set_inputs(input int c, input logic [7:0] base, input int early_row, input int row3_len);
    for (int i = 0; i < N; i++) begin
      int start, len;
      start = (i == early_row) ? i - 1 : i;
      len   = (i == N - 1) ? row3_len : N;
      if (c >= start && c < start + len) begin
        bus.row_valid[i]        = 1'b1;
        bus.row_data[i*W +: W]  = base + 8'(16*i + (c - start));
      end else begin
        bus.row_valid[i]        = 1'b0;
        bus.row_data[i*W +: W]  = '0;
      end
    end
  endtask

  // Drives frame cycles 0..6 and returns at the cycle-7 negedge with inputs idle
  task automatic send_frame(input logic [7:0] base, input int early_row, input int row3_len);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      set_inputs(c, base, early_row, row3_len);
    end
    @(negedge clk);
    bus.row_valid = '0;
    bus.row_data  = '0;
  endtask

  task automatic test_reset();
    bus.row_valid = '0;
    bus.row_data  = '0;
    bus.c_ready   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.matrix_C !== '0) begin failures++; $display("FAIL reset_matrix got %h want 0", bus.matrix_C); end
    tests_run++;
    if ({bus.c_valid, busy, overflow, timeout_err, skew_err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got %b want 00000", {bus.c_valid, busy, overflow, timeout_err, skew_err});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_frame();
    bus.c_ready = 1'b1;
    send_frame(8'h00, -1, N);
    tests_run++;
    if (bus.c_valid !== 1'b1) begin failures++; $display("FAIL basic_valid_c7 got %b want 1", bus.c_valid); end
    tests_run++;
    if (bus.matrix_C !== exp_matrix(8'h00)) begin failures++; $display("FAIL basic_matrix got %h want %h", bus.matrix_C, exp_matrix(8'h00)); end
    tests_run++;
    if (bus.matrix_C[7:0] !== 8'h00) begin failures++; $display("FAIL basic_c00 got %h want 00", bus.matrix_C[7:0]); end
    tests_run++;
    if (bus.matrix_C[127:120] !== 8'h33) begin failures++; $display("FAIL basic_c33 got %h want 33", bus.matrix_C[127:120]); end
    tests_run++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_hold got %b want 0", busy); end
    @(negedge clk);
    tests_run++;
    if (bus.c_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_c8 got %b want 0", bus.c_valid); end
    tests_run++;
    if ({overflow, timeout_err, skew_err} !== 3'b0) begin
      failures++; $display("FAIL basic_errors got %b want 000", {overflow, timeout_err, skew_err});
    end
    bus.c_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.c_ready = 1'b0;
    send_frame(8'h40, -1, N);
    tests_run++;
    if (bus.c_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got %b want 1", bus.c_valid); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus.c_valid !== 1'b1 || bus.matrix_C !== exp_matrix(8'h40)) begin
        failures++; $display("FAIL bp_hold_%0d got valid=%b data=%h want valid=1 data=%h", k, bus.c_valid, bus.matrix_C, exp_matrix(8'h40));
      end
    end
    bus.c_ready = 1'b1;
    @(negedge clk);
    bus.c_ready = 1'b0;
    tests_run++;
    if (bus.c_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_release got valid=%b busy=%b want 0 0", bus.c_valid, busy);
    end
    tests_run++;
    if (bus.matrix_C !== exp_matrix(8'h40)) begin failures++; $display("FAIL bp_keep got %h want %h", bus.matrix_C, exp_matrix(8'h40)); end
    @(negedge clk);
    tests_run++;
    if (bus.c_valid !== 1'b0) begin failures++; $display("FAIL bp_single_handshake got %b want 0", bus.c_valid); end
  endtask

  task automatic test_back_to_back();
    bus.c_ready = 1'b0;
    send_frame(8'h00, -1, N);
    send_frame(8'h80, -1, N);
    tests_run++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL b2b_overflow got %b want 1", overflow); end
    tests_run++;
    if (bus.c_valid !== 1'b1 || bus.matrix_C !== exp_matrix(8'h00)) begin
      failures++; $display("FAIL b2b_matrix got valid=%b data=%h want valid=1 data=%h", bus.c_valid, bus.matrix_C, exp_matrix(8'h00));
    end
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    tests_run++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_clear got %b want 0", overflow); end
    bus.c_ready = 1'b1;
    @(negedge clk);
    bus.c_ready = 1'b0;
    tests_run++;
    if (bus.c_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got %b want 0", bus.c_valid); end
  endtask

  task automatic test_timeout();
    bus.c_ready = 1'b0;
    send_frame(8'h00, -1, 2);
    tests_run++;
    if (busy !== 1'b1) begin failures++; $display("FAIL to_busy got %b want 1", busy); end
    // Last element on cycle 5; idle cycles counted from cycle 6
    repeat (14) @(negedge clk);
    tests_run++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL to_early got to=%b busy=%b want 0 1", timeout_err, busy);
    end
    @(negedge clk);
    tests_run++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_flag got %b want 1", timeout_err); end
    tests_run++;
    if (bus.c_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL to_state got valid=%b busy=%b want 0 0", bus.c_valid, busy);
    end
    bus.c_ready = 1'b1;
    send_frame(8'h10, -1, N);
    tests_run++;
    if (bus.c_valid !== 1'b1 || bus.matrix_C !== exp_matrix(8'h10)) begin
      failures++; $display("FAIL to_next_frame got valid=%b data=%h want valid=1 data=%h", bus.c_valid, bus.matrix_C, exp_matrix(8'h10));
    end
    tests_run++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky got %b want 1", timeout_err); end
    @(negedge clk);
    bus.c_ready = 1'b0;
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    tests_run++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_clear got %b want 0", timeout_err); end
  endtask

  task automatic test_reset_mid_collect();
    bus.c_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_inputs(c, 8'h55, -1, N);
    end
    @(negedge clk);
    bus.row_valid = '0;
    tests_run++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.matrix_C !== '0 || {bus.c_valid, busy, overflow, timeout_err, skew_err} !== 5'b0) begin
      failures++; $display("FAIL rst_mid_async got data=%h flags=%b want 0", bus.matrix_C, {bus.c_valid, busy, overflow, timeout_err, skew_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.c_ready = 1'b1;
    send_frame(8'h20, -1, N);
    tests_run++;
    if (bus.c_valid !== 1'b1 || bus.matrix_C !== exp_matrix(8'h20)) begin
      failures++; $display("FAIL rst_mid_frame got valid=%b data=%h want valid=1 data=%h", bus.c_valid, bus.matrix_C, exp_matrix(8'h20));
    end
    @(negedge clk);
    bus.c_ready = 1'b0;
  endtask

`ifdef SYSTOLIC_DRAIN_SKEW_CHECK_EN
  task automatic test_skew();
    bus.c_ready = 1'b1;
    send_frame(8'h00, 2, N);
    tests_run++;
    if (skew_err !== 1'b1) begin failures++; $display("FAIL skew_flag got %b want 1", skew_err); end
    tests_run++;
    if (bus.c_valid !== 1'b1 || bus.matrix_C !== exp_matrix(8'h00)) begin
      failures++; $display("FAIL skew_data got valid=%b data=%h want valid=1 data=%h", bus.c_valid, bus.matrix_C, exp_matrix(8'h00));
    end
    @(negedge clk);
    bus.c_ready = 1'b0;
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    tests_run++;
    if (skew_err !== 1'b0) begin failures++; $display("FAIL skew_clear got %b want 0", skew_err); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid_collect();
`ifdef SYSTOLIC_DRAIN_SKEW_CHECK_EN
    test_skew();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Output end of the 4x4 systolic matrix multiplier; counterpart to the input passers that skew A/B operands into the PE array.
- Accepts per-row result streams leaving the east edge of the array. Row i is delayed i cycles relative to row 0.
- Deskews and packs the streams into one flat matrix_C word.
- Presents matrix_C to the consumer with a valid/ready handshake, and flags protocol errors.

Parameters:
- N, 4, array dimension (rows = columns = N).
- W, 8, element width in bits; matrix_C width = N*N*W (128 at defaults).
- TIMEOUT, 16, idle cycles allowed mid-collection before abort; minimum 2.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- row_data  input  N*W  row i element at row_data[i*W +: W].
- row_valid  input  N  row i element present this cycle.
- c_ready  input  1  consumer accepts matrix_C when high with c_valid.
- err_clear  input  1  synchronous clear of sticky error flags.
- matrix_C  output  N*N*W  packed result; element C[i][j] at matrix_C[(i*N+j)*W +: W].
- c_valid  output  1  matrix_C holds a complete result.
- busy  output  1  high in COLLECT.
- overflow  output  1  sticky; an element was dropped.
- timeout_err  output  1  sticky; a collection was aborted.
- skew_err  output  1  sticky; present only with SKEW_CHECK_EN, otherwise tied 0.

Behaviour:
- Reset (reset=0, asynchronous) clears everything regardless of state:
  - matrix_C=0, c_valid=0, busy=0, all error flags=0.
  - Staging registers and row counters=0; state=IDLE.
  - Any partial frame is discarded.
- Per-row counter cnt[i], range 0..N:
  - An accepted element from row i is written to staging C[i][cnt[i]], then cnt[i] increments.
  - Rows are independent, so multiple rows may write in the same cycle.
- State IDLE:
  - Any row_valid bit set -> accept those elements, go to COLLECT.
  - Idle counter=0.
- State COLLECT:
  - busy=1.
  - row_valid[i] with cnt[i]<N -> accept.
  - row_valid[i] with cnt[i]==N -> drop the element, set overflow.
  - Idle counter increments on cycles with no row_valid and resets on any accepted element.
  - When every cnt[i]==N at the clock edge:
    - Copy staging to matrix_C, set c_valid, clear the counters.
    - Go to HOLD.
    - c_valid rises on the cycle after the last element is accepted (latency 1).
  - Idle counter reaching TIMEOUT:
    - Set timeout_err, clear the counters and staging, go to IDLE.
    - matrix_C and c_valid are unchanged.
- State HOLD:
  - matrix_C is stable; c_valid=1 until a cycle with c_ready=1.
  - On c_valid & c_ready: c_valid=0 on the next edge, go to IDLE. matrix_C keeps its last value.
  - row_valid while in HOLD (including the handshake cycle) -> element dropped, overflow set. There is no second buffer.
- Simultaneous events:
  - err_clear and a new error in the same cycle -> the error wins and the flag stays 1.
  - Timeout and completion in the same cycle are impossible, because completion requires an accepted element.
- Arithmetic: elements are stored verbatim (W bits); there is no truncation or sign handling.

Optional Feature:
- Macro: SYSTOLIC_DRAIN_SKEW_CHECK_EN.
- Defined:
  - Tracks the cycle offset of each row's first element relative to row 0's first element in the frame.
  - Row i's first element must arrive exactly i cycles after row 0's, and each row's N elements must arrive on consecutive cycles.
  - Any violation sets skew_err (sticky, cleared by err_clear). The data is still accepted.
- Undefined: no tracking logic; skew_err is driven 0.

Test Plan:
- Skewed 4x4 frame, C[i][j]=16*i+j: row i streams on cycles i..i+3 after start, c_ready=1 -> c_valid=1 at cycle 7, matrix_C[7:0]=0x00, matrix_C[127:120]=0x33, c_valid=0 at cycle 8, no errors.
- Same frame, c_ready=0 for 5 cycles after c_valid, then 1 -> matrix_C is stable throughout, a single handshake occurs, state returns to IDLE.
- Back-to-back frame starting during HOLD -> overflow=1, dropped elements do not alter matrix_C; err_clear=1 one cycle -> overflow=0.
- Rows 0-2 complete, row 3 sends 2 elements then stops -> timeout_err=1 exactly TIMEOUT cycles after the last element, c_valid stays 0; the next full frame completes correctly.
- reset pulled low mid-COLLECT (after 6 elements) -> all outputs 0 immediately (asynchronous); a full frame after release completes normally.
- With SYSTOLIC_DRAIN_SKEW_CHECK_EN: row 2 starts 1 cycle early -> skew_err=1, and the frame still completes with correct data.
